// File: rtl/ndff_sync_pkg.sv
// ndff_sync_pkg: shared constants and helpers for the multi-channel synchroniser/filter.
package ndff_sync_pkg;
  localparam int DEFAULT_NUM_OF_FLOPS = 2;
  function automatic int cnt_width(input int f);
    return (f < 1) ? 1 : $clog2(f + 1);
  endfunction
endpackage

// File: rtl/ndff_bus_sync_filter_if.sv
// ndff_bus_sync_filter_if: async level inputs and synchronised level/pulse outputs.
//   D_in         async level inputs, one bit per channel
//   D_out        synchronised (optionally deglitched) levels
//   rise_pulse   1-cycle pulse on D_out 0->1
//   fall_pulse   1-cycle pulse on D_out 1->0
//   change_pulse rise_pulse | fall_pulse
interface ndff_bus_sync_filter_if #(parameter int NUM_CHANNELS = 4);
  logic [NUM_CHANNELS-1:0] D_in, D_out, rise_pulse, fall_pulse, change_pulse;
  modport master (output D_in, input D_out, rise_pulse, fall_pulse, change_pulse);
  modport slave (input D_in, output D_out, rise_pulse, fall_pulse, change_pulse);
endinterface

// File: rtl/ndff_filter_chan.sv
// ndff_filter_chan: one channel - N-flop synchroniser, optional stability filter, edge pulses.
//   dest_clk/rst  clock, async active-high reset (all state loads RESET_VAL)
//   d_in          async level input
//   d_out         synchronised/filtered level
//   rise/fall/change  single-cycle pulses aligned with the first cycle of a new d_out
module ndff_filter_chan import ndff_sync_pkg::*; #(
  parameter int NUM_OF_FLOPS = DEFAULT_NUM_OF_FLOPS,
  parameter int FILTER_CYCLES = 0,
  parameter logic RESET_VAL = 1'b0
) (
  input logic dest_clk,
  input logic rst,
  input logic d_in,
  output logic d_out,
  output logic rise,
  output logic fall,
  output logic change
);
  logic [NUM_OF_FLOPS-1:0] chain;
  logic sync_q, d_prev;
  always_ff @(posedge dest_clk or posedge rst)
    if (rst) chain <= {NUM_OF_FLOPS{RESET_VAL}};
    else chain <= {chain[NUM_OF_FLOPS-2:0], d_in};
  assign sync_q = chain[NUM_OF_FLOPS-1];
  if (FILTER_CYCLES == 0) begin : g_bypass
    assign d_out = sync_q;
  end else begin : g_filt
    localparam int CW = cnt_width(FILTER_CYCLES);
    logic [CW-1:0] cnt;
    // cnt counts consecutive cycles of disagreement; any agreement restarts it
    always_ff @(posedge dest_clk or posedge rst)
      if (rst) begin
        cnt <= '0;
        d_out <= RESET_VAL;
      end else if (sync_q == d_out) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
        cnt <= '0;
        d_out <= sync_q;
      end else begin
        cnt <= cnt + CW'(1);
      end
  end
  always_ff @(posedge dest_clk or posedge rst)
    if (rst) d_prev <= RESET_VAL;
    else d_prev <= d_out;
  assign rise = d_out & ~d_prev;
  assign fall = ~d_out & d_prev;
  assign change = rise | fall;
endmodule

// File: rtl/ndff_bus_sync_filter.sv
// ndff_bus_sync_filter: NUM_CHANNELS independent async levels synchronised into dest_clk.
//   dest_clk  the only clock
//   rst       async active-high reset; everything returns to RESET_VALUE, pulses 0
//   bus       slave side of ndff_bus_sync_filter_if (D_in in; D_out and pulses out)
module ndff_bus_sync_filter import ndff_sync_pkg::*; #(
  parameter int NUM_CHANNELS = 4,
  parameter int NUM_OF_FLOPS = DEFAULT_NUM_OF_FLOPS,
  parameter int FILTER_CYCLES = 0,
  parameter logic [NUM_CHANNELS-1:0] RESET_VALUE = '0
) (
  input logic dest_clk,
  input logic rst,
  ndff_bus_sync_filter_if.slave bus
);
  logic [NUM_CHANNELS-1:0] d_out, rise, fall, change;
  if (NUM_OF_FLOPS < 2) begin : g_bad_flops
    $error("ndff_bus_sync_filter: NUM_OF_FLOPS must be >= 2");
  end
  if (NUM_CHANNELS < 1) begin : g_bad_chans
    $error("ndff_bus_sync_filter: NUM_CHANNELS must be >= 1");
  end
  if (FILTER_CYCLES < 0) begin : g_bad_filter
    $error("ndff_bus_sync_filter: FILTER_CYCLES must be >= 0");
  end
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    ndff_filter_chan #(
      .NUM_OF_FLOPS(NUM_OF_FLOPS),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_VAL(RESET_VALUE[i])
    ) u_chan (
      .dest_clk(dest_clk),
      .rst(rst),
      .d_in(bus.D_in[i]),
      .d_out(d_out[i]),
      .rise(rise[i]),
      .fall(fall[i]),
      .change(change[i])
    );
  end
  assign bus.D_out = d_out;
  assign bus.rise_pulse = rise;
  assign bus.fall_pulse = fall;
  assign bus.change_pulse = change;
endmodule

// File: tb/tb_ndff_bus_sync_filter.sv
// tb_ndff_bus_sync_filter: two configurations (N=3/F=0 and N=2/F=4) driven in parallel,
// checked cycle by cycle against a delay-line / stability-window reference model.
module tb_ndff_bus_sync_filter;
  localparam int NC = 4;
  localparam logic [NC-1:0] RV = 4'b0101;
  localparam int NA = 3, FA = 0, NB = 2, FB = 4;

  typedef struct packed {
    logic [NC-1:0] oa, ra, fa, ob, rb, fb;
  } exp_t;

  logic dest_clk = 1'b0;
  logic rst = 1'b1;
  logic [NC-1:0] din_q = RV;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // reference model state: input delay lines, sync-value history, outputs
  logic [NC-1:0] sa_q[$], sb_q[$], hb_q[$];
  logic [NC-1:0] outa, preva, outb, prevb;

  ndff_bus_sync_filter_if #(.NUM_CHANNELS(NC)) bus_a ();
  ndff_bus_sync_filter_if #(.NUM_CHANNELS(NC)) bus_b ();

  ndff_bus_sync_filter #(.NUM_CHANNELS(NC), .NUM_OF_FLOPS(NA), .FILTER_CYCLES(FA), .RESET_VALUE(RV))
    dut_a (.dest_clk(dest_clk), .rst(rst), .bus(bus_a));
  ndff_bus_sync_filter #(.NUM_CHANNELS(NC), .NUM_OF_FLOPS(NB), .FILTER_CYCLES(FB), .RESET_VALUE(RV))
    dut_b (.dest_clk(dest_clk), .rst(rst), .bus(bus_b));

  always #5 dest_clk = ~dest_clk;

  task automatic model_reset();
    sa_q.delete();
    sb_q.delete();
    hb_q.delete();
    repeat (NA) sa_q.push_back(RV);
    repeat (NB) sb_q.push_back(RV);
    repeat (FB) hb_q.push_back(RV);
    outa = RV;
    preva = RV;
    outb = RV;
    prevb = RV;
  endtask

  // A: output is the input delayed by NA edges.
  // B: a bit flips once its last FB synchronised samples all differ from the output.
  task automatic model_edge(input logic [NC-1:0] d);
    logic [NC-1:0] flip;
    flip = '1;
    preva = outa;
    prevb = outb;
    sa_q.push_back(d);
    void'(sa_q.pop_front());
    outa = sa_q[0];
    foreach (hb_q[j]) flip &= hb_q[j] ^ outb;
    outb = outb ^ flip;
    sb_q.push_back(d);
    void'(sb_q.pop_front());
    hb_q.push_back(sb_q[0]);
    void'(hb_q.pop_front());
  endtask

  task automatic step(input logic r, input logic [NC-1:0] d);
    exp_t e;
    @(posedge dest_clk);
    if (!rst) model_edge(din_q);
    #1;
    rst = r;
    din_q = d;
    bus_a.D_in = d;
    bus_b.D_in = d;
    if (r) model_reset();
    e.oa = outa;
    e.ra = outa & ~preva;
    e.fa = ~outa & preva;
    e.ob = outb;
    e.rb = outb & ~prevb;
    e.fb = ~outb & prevb;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [NC-1:0] d, input int n);
    repeat (n) step(1'b0, d);
  endtask

  task automatic check(input string name, input logic [NC-1:0] act, input logic [NC-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge dest_clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("a_d_out", bus_a.D_out, e.oa);
        check("a_rise", bus_a.rise_pulse, e.ra);
        check("a_fall", bus_a.fall_pulse, e.fa);
        check("a_change", bus_a.change_pulse, e.ra | e.fa);
        check("b_d_out", bus_b.D_out, e.ob);
        check("b_rise", bus_b.rise_pulse, e.rb);
        check("b_fall", bus_b.fall_pulse, e.fb);
        check("b_change", bus_b.change_pulse, e.rb | e.fb);
      end
    end
  end

  initial begin : stim
    logic [NC-1:0] d;
    bus_a.D_in = RV;
    bus_b.D_in = RV;
    model_reset();
    repeat (3) step(1'b1, RV);
    hold(RV, 10);
    hold(4'b0100, 8);
    hold(4'b0101, 8);
    hold(4'b0001, 10);
    hold(4'b0101, 3);
    hold(4'b0001, 6);
    hold(4'b0101, 8);
    hold(4'b0111, 10);
    hold(4'b0101, 10);
    repeat (6) begin
      hold(4'b0000, 1);
      hold(4'b1111, 1);
    end
    hold(4'b0000, 10);
    hold(4'b1111, 10);
    hold(4'b0000, 10);
    hold(4'b1111, 3);
    repeat (2) step(1'b1, 4'hF);
    hold(4'hF, 10);
    d = RV;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) d = 4'($urandom);
      if ($urandom_range(0, 99) == 0) step(1'b1, d);
      else step(1'b0, d);
    end
    hold(d, 8);
    @(negedge dest_clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
